uart_rx: RTL and testbench

Serial receiver for the board UART link, the receive side of the existing 8N1 transmitter. Runs on the same 16×-baud `clk` (one bit = 16 clocks). It synchronizes the incoming line, finds the start bit, and majority-samples each bit at mid-period. Completed bytes are buffered in a small show-ahead FIFO for the consuming logic (keyboard/command decoder), with sticky framing and overrun flags.

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver: FIFO head, pop strobe and sticky error flags.
// The receiver takes the slave modport; the consuming logic takes master.
interface uart_rx_if;
  logic       rd;
  logic       clr_err;
  logic [7:0] data_received;
  logic       received;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rd,
    output clr_err,
    input  data_received,
    input  received,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  rd,
    input  clr_err,
    output data_received,
    output received,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver on a 16x-baud clock: two-flop line sync, 2-of-3 mid-bit vote,
// show-ahead byte FIFO with sticky framing and overrun flags.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      bit_in,
  uart_rx_if.slave  bus
);

  localparam int CW   = $clog2(OVERSAMPLE);
  localparam int HALF = OVERSAMPLE / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);

  // Phases are named by the value cnt takes after the edge, so the register
  // values seen at the sample edges are one lower than the nominal 7/8/9.
  localparam logic [CW-1:0] SAMP_A  = CW'(HALF - 2);
  localparam logic [CW-1:0] SAMP_B  = CW'(HALF - 1);
  localparam logic [CW-1:0] VOTE_AT = CW'(HALF);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg;
  logic          sync_reg;
  logic          rx_s_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          samp_a_reg;
  logic          samp_b_reg;
  logic          frame_err_reg;
  logic          overrun_reg;
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [7:0]    mem_reg [FIFO_DEPTH];

  logic          vote;
  logic          at_vote;
  logic          at_wrap;
  logic [CW-1:0] cnt_step;
  logic          push;
  logic          bad_stop;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          overflow;

  always_comb begin
    vote     = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s_reg) | (samp_b_reg & rx_s_reg);
    at_vote  = (cnt_reg == VOTE_AT);
    at_wrap  = (cnt_reg == LAST);
    cnt_step = at_wrap ? '0 : cnt_reg + 1'b1;
    push     = (state_reg == STOP) && at_vote && vote;
    bad_stop = (state_reg == STOP) && at_vote && !vote;
    empty    = (wr_ptr_reg == rd_ptr_reg);
    full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
               (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    pop      = bus.rd && !empty;
    // A full FIFO still takes the byte when the head leaves on the same edge.
    push_ok  = push && (!full || pop);
    overflow = push && !push_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg      <= 1'b1;
      rx_s_reg      <= 1'b1;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      samp_a_reg    <= 1'b1;
      samp_b_reg    <= 1'b1;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      sync_reg <= bit_in;
      rx_s_reg <= sync_reg;
      if (cnt_reg == SAMP_A) samp_a_reg <= rx_s_reg;
      if (cnt_reg == SAMP_B) samp_b_reg <= rx_s_reg;

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rx_s_reg) begin
            state_reg   <= START;
            bit_idx_reg <= '0;
          end
        end
        START: begin
          cnt_reg <= cnt_step;
          if (at_vote && vote) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (at_wrap) begin
            state_reg   <= DATA;
            bit_idx_reg <= 4'd1;
          end
        end
        DATA: begin
          cnt_reg <= cnt_step;
          if (at_vote) shift_reg <= {vote, shift_reg[7:1]};
          if (at_wrap) begin
            if (bit_idx_reg == 4'd8) state_reg <= STOP;
            bit_idx_reg <= bit_idx_reg + 4'd1;
          end
        end
        STOP: begin
          cnt_reg <= cnt_step;
          // Leaving on the vote edge leaves half a bit to catch a back-to-back start.
          if (at_vote) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (bad_stop)         frame_err_reg <= 1'b1;
      else if (bus.clr_err) frame_err_reg <= 1'b0;
      if (overflow)         overrun_reg   <= 1'b1;
      else if (bus.clr_err) overrun_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= shift_reg;
  end

  // Head is masked while empty so stale storage never shows after reset or the last pop.
  assign bus.data_received = empty ? 8'h00 : mem_reg[rd_ptr_reg[AW-1:0]];
  assign bus.received      = !empty;
  assign bus.frame_err     = frame_err_reg;
  assign bus.overrun       = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit-serially at 16 clk/bit and
// every check is an immediate assertion against a hand-computed value.
module tb_uart_rx;
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic bit_in = 1'b1;

  uart_rx_if bus_if ();

  uart_rx #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_in (bit_in),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  logic rcv_pre;
  logic rcv_post;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit_in = 1'b1;
    repeat (n) tick();
  endtask

  // Frame cycle n drives bit n/16; the stop vote lands on the edge of cycle 156.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int spike_n, input int rd_n, input int abort_n);
    int   b;
    logic v;
    for (int n = 0; n < 160; n++) begin
      tick();
      b = n / 16;
      if (b == 0)      v = 1'b0;
      else if (b == 9) v = stop;
      else             v = d[b-1];
      if (n == spike_n) v = ~v;
      bit_in = v;
      if (n == 155) rcv_pre  = bus_if.received;
      if (n == 156) rcv_post = bus_if.received;
      if (n == rd_n)     bus_if.rd = 1'b1;
      if (n == rd_n + 1) bus_if.rd = 1'b0;
      if (n == abort_n) begin
        rst_n = 1'b0;
        break;
      end
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk({tag, "_recv"}, {7'd0, bus_if.received}, 8'h01);
    chk(tag, bus_if.data_received, exp);
    bus_if.rd = 1'b1;
    tick();
    bus_if.rd = 1'b0;
  endtask

  task automatic pulse_clr();
    bus_if.clr_err = 1'b1;
    tick();
    bus_if.clr_err = 1'b0;
  endtask

  initial begin
    bus_if.rd      = 1'b0;
    bus_if.clr_err = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_received", {7'd0, bus_if.received}, 8'h00);
    chk("rst_data", bus_if.data_received, 8'h00);
    chk("rst_frame_err", {7'd0, bus_if.frame_err}, 8'h00);
    chk("rst_overrun", {7'd0, bus_if.overrun}, 8'h00);
    rst_n = 1'b1;
    idle(5);

    // Single byte with receive timing around the stop vote
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    chk("a5_before_vote", {7'd0, rcv_pre}, 8'h00);
    chk("a5_after_vote", {7'd0, rcv_post}, 8'h01);
    chk("a5_frame_err", {7'd0, bus_if.frame_err}, 8'h00);
    chk("a5_overrun", {7'd0, bus_if.overrun}, 8'h00);
    pop_check("a5_data", 8'hA5);
    chk("a5_empty", {7'd0, bus_if.received}, 8'h00);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, -1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1, -1);
    send_frame(8'h3C, 1'b1, -1, -1, -1);
    send_frame(8'h81, 1'b1, -1, -1, -1);
    idle(4);
    chk("b2b_frame_err", {7'd0, bus_if.frame_err}, 8'h00);
    chk("b2b_overrun", {7'd0, bus_if.overrun}, 8'h00);
    pop_check("b2b_0", 8'h00);
    pop_check("b2b_1", 8'hFF);
    pop_check("b2b_2", 8'h3C);
    pop_check("b2b_3", 8'h81);
    chk("b2b_empty", {7'd0, bus_if.received}, 8'h00);

    // Overrun: fifth byte dropped, sixth accepted by a pop on its vote edge
    send_frame(8'h11, 1'b1, -1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1, -1);
    send_frame(8'h33, 1'b1, -1, -1, -1);
    send_frame(8'h44, 1'b1, -1, -1, -1);
    chk("ovr_not_yet", {7'd0, bus_if.overrun}, 8'h00);
    send_frame(8'h55, 1'b1, -1, -1, -1);
    chk("ovr_set", {7'd0, bus_if.overrun}, 8'h01);
    chk("ovr_head", bus_if.data_received, 8'h11);
    send_frame(8'h66, 1'b1, -1, 155, -1);
    idle(2);
    chk("ovr_sticky", {7'd0, bus_if.overrun}, 8'h01);
    pop_check("ovr_0", 8'h22);
    pop_check("ovr_1", 8'h33);
    pop_check("ovr_2", 8'h44);
    pop_check("ovr_3", 8'h66);
    chk("ovr_empty", {7'd0, bus_if.received}, 8'h00);
    chk("ovr_still_set", {7'd0, bus_if.overrun}, 8'h01);
    pulse_clr();
    chk("ovr_cleared", {7'd0, bus_if.overrun}, 8'h00);

    // Framing error, then a good byte
    send_frame(8'h55, 1'b0, -1, -1, -1);
    idle(20);
    chk("fe_set", {7'd0, bus_if.frame_err}, 8'h01);
    chk("fe_no_push", {7'd0, bus_if.received}, 8'h00);
    send_frame(8'h12, 1'b1, -1, -1, -1);
    chk("fe_sticky", {7'd0, bus_if.frame_err}, 8'h01);
    pop_check("fe_good", 8'h12);
    pulse_clr();
    chk("fe_cleared", {7'd0, bus_if.frame_err}, 8'h00);

    // Start glitch on an idle line
    idle(5);
    bit_in = 1'b0;
    repeat (3) tick();
    idle(40);
    chk("glitch_recv", {7'd0, bus_if.received}, 8'h00);
    chk("glitch_fe", {7'd0, bus_if.frame_err}, 8'h00);

    // One-clock spike mid data bit 3
    send_frame(8'hF0, 1'b1, 4 * 16 + 8, -1, -1);
    chk("spike_fe", {7'd0, bus_if.frame_err}, 8'h00);
    pop_check("spike_data", 8'hF0);

    // Reset mid-frame with bytes queued and a flag set
    send_frame(8'h00, 1'b0, -1, -1, -1);
    idle(20);
    send_frame(8'hC3, 1'b1, -1, -1, -1);
    send_frame(8'h5A, 1'b1, -1, -1, -1);
    chk("pre_rst_recv", {7'd0, bus_if.received}, 8'h01);
    chk("pre_rst_fe", {7'd0, bus_if.frame_err}, 8'h01);
    send_frame(8'h99, 1'b1, -1, -1, 5 * 16 + 4);
    #1;
    chk("mid_rst_recv", {7'd0, bus_if.received}, 8'h00);
    chk("mid_rst_data", bus_if.data_received, 8'h00);
    chk("mid_rst_fe", {7'd0, bus_if.frame_err}, 8'h00);
    chk("mid_rst_ovr", {7'd0, bus_if.overrun}, 8'h00);
    bit_in = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h7E, 1'b1, -1, -1, -1);
    pop_check("post_rst_data", 8'h7E);
    chk("post_rst_alone", {7'd0, bus_if.received}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
